// File: rtl/lcd_bus_arbiter_pkg.sv
// Shared types and timing constants for the LCD bus arbiter (20 ns clock).
// The power-on write list here is only used when LCD_AUTOINIT_EN is defined.
package lcd_pkg;

  typedef enum logic [2:0] {
    INIT,
    ARB,
    SETUP,
    ENABLE,
    HOLD,
    WAIT
  } lcd_state_e;

  localparam int LCD_NS_PER_CYC = 20;
  localparam int LCD_CYC_PER_US = 1000 / LCD_NS_PER_CYC;
  localparam int LCD_CYC_PER_MS = 1000 * LCD_CYC_PER_US;
  localparam int LCD_SETUP_CYC  = 2;
  localparam int LCD_PULSE_CYC  = 500 / LCD_NS_PER_CYC;
  localparam int LCD_CODE_W     = 5;
  localparam int LCD_INIT_LEN   = 8;

  typedef struct packed {
    logic [LCD_CODE_W-1:0] code;
    logic                  rs;
    logic [7:0]            d;
  } lcd_wr_t;

  // Smallest power-of-two exponent covering the requested number of cycles.
  function automatic logic [LCD_CODE_W-1:0] lcd_delay_code(input int cycles);
    return LCD_CODE_W'($clog2(cycles));
  endfunction

  localparam lcd_wr_t LCD_INIT_ROM [LCD_INIT_LEN] = '{
    lcd_wr_t'{code: lcd_delay_code(150 * LCD_CYC_PER_MS), rs: 1'b0, d: 8'h30},
    lcd_wr_t'{code: lcd_delay_code(5 * LCD_CYC_PER_MS),   rs: 1'b0, d: 8'h30},
    lcd_wr_t'{code: lcd_delay_code(120 * LCD_CYC_PER_US), rs: 1'b0, d: 8'h30},
    lcd_wr_t'{code: lcd_delay_code(120 * LCD_CYC_PER_US), rs: 1'b0, d: 8'h38},
    lcd_wr_t'{code: lcd_delay_code(55 * LCD_CYC_PER_US),  rs: 1'b0, d: 8'h08},
    lcd_wr_t'{code: lcd_delay_code(3 * LCD_CYC_PER_MS),   rs: 1'b0, d: 8'h01},
    lcd_wr_t'{code: lcd_delay_code(55 * LCD_CYC_PER_US),  rs: 1'b0, d: 8'h06},
    lcd_wr_t'{code: lcd_delay_code(55 * LCD_CYC_PER_US),  rs: 1'b0, d: 8'h0C}
  };

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester-side handshake bundle: master drives requests, slave (the arbiter)
// returns the one-hot accept strobe.
interface lcd_bus_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int NBITS_TIME = 5
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ*9-1:0]          req_data;
  logic [NREQ*NBITS_TIME-1:0] req_wait;
  logic [NREQ-1:0]            req_lock;
  logic [NREQ-1:0]            req_ready;

  modport master (
    output req_valid, req_data, req_wait, req_lock,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_data, req_wait, req_lock,
    output req_ready
  );
endinterface

// File: rtl/lcd_bus_arbiter_rr_arbiter.sv
// Round-robin winner selection with a sticky lock for multi-byte sequences.
// Pointer and lock state only advance on an accept strobe.
module lcd_rr_arbiter
  import lcd_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          valid,
  input  logic [NREQ-1:0]          lock,
  input  logic                     accept,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  grant_idx
);
  localparam int IW = $clog2(NREQ);
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] lock_id_q;
  logic          lock_q;
  logic [IW:0]   k;

  // Scan offsets from the far end so the offset nearest the pointer is written last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    k         = '0;
    if (lock_q) begin
      if (valid[lock_id_q]) begin
        grant[lock_id_q] = 1'b1;
        grant_idx        = lock_id_q;
      end
    end else begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        k = {1'b0, ptr_q} + (IW+1)'(i);
        if (k >= (IW+1)'(NREQ)) k = k - (IW+1)'(NREQ);
        if (valid[k[IW-1:0]]) begin
          grant              = '0;
          grant[k[IW-1:0]]   = 1'b1;
          grant_idx          = k[IW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (accept) begin
      ptr_q     <= (grant_idx == LAST) ? '0 : grant_idx + IW'(1);
      lock_q    <= lock[grant_idx];
      lock_id_q <= grant_idx;
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one HD44780-style LCD bus between NREQ requesters and generates E timing.
// Define LCD_AUTOINIT_EN to emit the power-on init sequence from reset.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int NBITS_TIME = 5,
  parameter int SETUP_CYC  = LCD_SETUP_CYC,
  parameter int PULSE_CYC  = LCD_PULSE_CYC
) (
  input  logic                     clk,
  input  logic                     reset,
  lcd_bus_arbiter_if.slave         req,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     LCD_RS,
  output logic                     LCD_E,
  output logic [7:0]               LCD_D
);
  // state  | meaning
  // INIT   | load next power-on write (LCD_AUTOINIT_EN only)
  // ARB    | idle, offering req_ready to the round-robin winner
  // SETUP  | RS/D stable, E low, SETUP_CYC cycles
  // ENABLE | E high, PULSE_CYC cycles
  // HOLD   | E low, RS/D held, PULSE_CYC cycles
  // WAIT   | post-write busy wait, 2^code cycles

  localparam int IW    = $clog2(NREQ);
  localparam int CNT_W = (2**NBITS_TIME > 16) ? 2**NBITS_TIME : 16;

  lcd_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NBITS_TIME-1:0]  wait_code_q;
  logic [CNT_W-1:0]       wait_load;
  logic [NREQ-1:0]        grant;
  logic [IW-1:0]          gidx;
  logic                   accept;
  logic                   init_done;

`ifdef LCD_AUTOINIT_EN
  localparam lcd_state_e RESET_STATE = INIT;
  logic [3:0] init_idx_q;
  lcd_wr_t    init_wr;
  assign init_done = (init_idx_q == 4'(LCD_INIT_LEN));
  assign init_wr   = LCD_INIT_ROM[init_idx_q[2:0]];
`else
  localparam lcd_state_e RESET_STATE = ARB;
  assign init_done = 1'b1;
`endif

  lcd_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .valid     (req.req_valid),
    .lock      (req.req_lock),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req.req_ready = (state_q == ARB) ? grant : '0;
  assign busy          = (state_q != ARB);
  assign LCD_E         = (state_q == ENABLE);
  assign wait_load     = (CNT_W'(1) << wait_code_q) - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  // Every timed phase is a down-counter loaded on entry and left at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ARB: begin
        if (|grant) begin
          accept  = 1'b1;
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end
      end
      INIT: begin
        state_d = SETUP;
        cnt_d   = CNT_W'(SETUP_CYC - 1);
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = ENABLE;
          cnt_d   = CNT_W'(PULSE_CYC - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ENABLE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(PULSE_CYC - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = WAIT;
          cnt_d   = wait_load;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      WAIT: begin
        if (cnt_q == '0) state_d = init_done ? ARB : INIT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      LCD_RS      <= 1'b0;
      LCD_D       <= '0;
      grant_id    <= '0;
      wait_code_q <= '0;
`ifdef LCD_AUTOINIT_EN
      init_idx_q  <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        {LCD_RS, LCD_D} <= req.req_data[int'(gidx)*9 +: 9];
        wait_code_q     <= req.req_wait[int'(gidx)*NBITS_TIME +: NBITS_TIME];
        grant_id        <= gidx;
      end
`ifdef LCD_AUTOINIT_EN
      if (state_q == INIT) begin
        LCD_RS      <= init_wr.rs;
        LCD_D       <= init_wr.d;
        wait_code_q <= NBITS_TIME'(init_wr.code);
        init_idx_q  <= init_idx_q + 4'd1;
      end
`endif
    end
  end

endmodule
